pb_port_bank: RTL and testbench

Parametrised I/O port bank that sits between the KCPSM6 processor and the peripheral controllers (RTC, PS/2, VGA, alarm). It generalises the fixed 16-output / 3-input decode to configurable port counts and data width. It adds three behaviours:
- one-cycle write and read pulses per port, so peripherals can pop FIFOs or start transactions;
- zero-filled reads of unmapped addresses;
- a maskable, edge-triggered interrupt controller with sticky status and write-1-to-clear.

---
 rtl/pb_port_pkg.sv | 9 +
 rtl/pb_irq_ctrl.sv | 37 +++
 rtl/pb_port_bank.sv | 94 +++++++++
 tb/tb_pb_port_bank.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/pb_port_pkg.sv
// pb_port_pkg: shared address map and parameter limits for the KCPSM6 port bank
package pb_port_pkg;

    localparam logic [7:0] ADDR_IRQ_STATUS = 8'hF0;
    localparam logic [7:0] ADDR_IRQ_MASK   = 8'hF1;
    localparam int         MAX_PORTS       = 240;
    localparam int         K_DECODE_BITS   = 4;

endpackage

// File: rtl/pb_irq_ctrl.sv
// pb_irq_ctrl: rising-edge interrupt capture with sticky status, mask, W1C and ack drop
module pb_irq_ctrl #(
    parameter int N_IRQ = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IRQ-1:0] irq_src,
    input  logic             status_clr_en,
    input  logic             mask_wr_en,
    input  logic [N_IRQ-1:0] wdata,
    input  logic             interrupt_ack,
    output logic [N_IRQ-1:0] status,
    output logic [N_IRQ-1:0] mask,
    output logic             interrupt
);

    logic [N_IRQ-1:0] prev;

    // edge history keeps tracking during reset so a source already high at release is not an edge
    always_ff @(posedge clk) begin
        prev <= irq_src;
    end

    // sticky flags (set beats clear), mask register and registered request with one-cycle ack drop
    always_ff @(posedge clk) begin
        if (reset) begin
            status    <= '0;
            mask      <= '0;
            interrupt <= 1'b0;
        end else begin
            status    <= (status & ~(status_clr_en ? wdata : '0)) | (irq_src & ~prev);
            mask      <= mask_wr_en ? wdata : mask;
            interrupt <= ~interrupt_ack & |(status & mask);
        end
    end

endmodule

// File: rtl/pb_port_bank.sv
// pb_port_bank: KCPSM6 I/O decode with output registers, read mux, access pulses and interrupts
module pb_port_bank
    import pb_port_pkg::*;
#(
    parameter int DW    = 8,
    parameter int N_OUT = 16,
    parameter int N_IN  = 4,
    parameter int N_IRQ = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        port_id,
    input  logic [DW-1:0]     out_port,
    input  logic              write_strobe,
    input  logic              k_write_strobe,
    input  logic              read_strobe,
    output logic [DW-1:0]     in_port,
    output logic              interrupt,
    input  logic              interrupt_ack,
    output logic [N_OUT*DW-1:0] out_regs,
    output logic [N_OUT-1:0]  out_wr_pulse,
    input  logic [N_IN*DW-1:0] in_data,
    output logic [N_IN-1:0]   in_rd_pulse,
    input  logic [N_IRQ-1:0]  irq_src
);

    if (N_OUT < 1 || N_OUT > MAX_PORTS || N_IN < 1 || N_IN > MAX_PORTS || N_IRQ < 1 || N_IRQ > DW) begin : g_bad_params
        $error("pb_port_bank: illegal parameter combination");
    end

    logic [N_OUT-1:0][DW-1:0] regs;
    logic [N_IN-1:0][DW-1:0]  ins;
    logic [7:0]               waddr;
    logic                     wr_en;
    logic [N_OUT-1:0]         wr_sel;
    logic [N_IN-1:0]          rd_sel;
    logic [DW-1:0]            rd_data;
    logic [N_IRQ-1:0]         status;
    logic [N_IRQ-1:0]         mask;

    assign out_regs = regs;
    assign ins      = in_data;

    // write decode: OUTPUT uses the full address and wins; OUTPUTK sees only the low nibble
    always_comb begin
        wr_en  = write_strobe ? 32'(port_id) < N_OUT
                              : k_write_strobe && 32'(port_id[K_DECODE_BITS-1:0]) < N_OUT;
        waddr  = write_strobe ? port_id : 8'(port_id[K_DECODE_BITS-1:0]);
        wr_sel = '0;
        for (int k = 0; k < N_OUT; k++) wr_sel[k] = wr_en && waddr == 8'(k);
    end

    // read mux: input ports, then IRQ registers, everything else reads zero
    always_comb begin
        rd_data = port_id == ADDR_IRQ_STATUS ? DW'(status) :
                  port_id == ADDR_IRQ_MASK   ? DW'(mask)   : '0;
        rd_sel  = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (port_id == 8'(i)) begin
                rd_data   = ins[i];
                rd_sel[i] = read_strobe;
            end
        end
    end

    // output registers, access pulses and registered read data
    always_ff @(posedge clk) begin
        if (reset) begin
            regs         <= '0;
            out_wr_pulse <= '0;
            in_rd_pulse  <= '0;
            in_port      <= '0;
        end else begin
            for (int k = 0; k < N_OUT; k++) if (wr_sel[k]) regs[k] <= out_port;
            out_wr_pulse <= wr_sel;
            in_rd_pulse  <= rd_sel;
            in_port      <= rd_data;
        end
    end

    pb_irq_ctrl #(.N_IRQ(N_IRQ)) u_irq (
        .clk           (clk),
        .reset         (reset),
        .irq_src       (irq_src),
        .status_clr_en (write_strobe && port_id == ADDR_IRQ_STATUS),
        .mask_wr_en    (write_strobe && port_id == ADDR_IRQ_MASK),
        .wdata         (out_port[N_IRQ-1:0]),
        .interrupt_ack (interrupt_ack),
        .status        (status),
        .mask          (mask),
        .interrupt     (interrupt)
    );

endmodule

// File: tb/tb_pb_port_bank.sv
// tb_pb_port_bank: directed checks of write, OUTPUTK, read, IRQ and reset behaviour
module tb_pb_port_bank;

    logic         clk = 1'b0;
    logic         reset;
    logic [7:0]   port_id;
    logic [7:0]   out_port;
    logic         write_strobe;
    logic         k_write_strobe;
    logic         read_strobe;
    logic [7:0]   in_port;
    logic         interrupt;
    logic         interrupt_ack;
    logic [127:0] out_regs;
    logic [15:0]  out_wr_pulse;
    logic [31:0]  in_data;
    logic [3:0]   in_rd_pulse;
    logic [3:0]   irq_src;

    logic [127:0] exp_regs;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pb_port_bank dut (
        .clk            (clk),
        .reset          (reset),
        .port_id        (port_id),
        .out_port       (out_port),
        .write_strobe   (write_strobe),
        .k_write_strobe (k_write_strobe),
        .read_strobe    (read_strobe),
        .in_port        (in_port),
        .interrupt      (interrupt),
        .interrupt_ack  (interrupt_ack),
        .out_regs       (out_regs),
        .out_wr_pulse   (out_wr_pulse),
        .in_data        (in_data),
        .in_rd_pulse    (in_rd_pulse),
        .irq_src        (irq_src)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        write_strobe   = 1'b0;
        k_write_strobe = 1'b0;
        read_strobe    = 1'b0;
        interrupt_ack  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; idle(); port_id = 8'h80; out_port = 8'h00;
        in_data = 32'h445E2211; irq_src = 4'hF;
        step(); step();
        reset = 1'b0;
        step();
        checks++; if (out_regs !== 128'h0) begin errors++; $display("FAIL reset_regs: got %h expected 0", out_regs); end
        checks++; if (out_wr_pulse !== 16'h0) begin errors++; $display("FAIL reset_wr_pulse: got %h expected 0", out_wr_pulse); end
        checks++; if (in_rd_pulse !== 4'h0) begin errors++; $display("FAIL reset_rd_pulse: got %h expected 0", in_rd_pulse); end
        checks++; if (in_port !== 8'h00) begin errors++; $display("FAIL reset_in_port: got %h expected 00", in_port); end
        checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL reset_interrupt: got %b expected 0", interrupt); end
        port_id = 8'hF0; step(); step();
        checks++; if (in_port !== 8'h00) begin errors++; $display("FAIL reset_status_high_src: got %h expected 00", in_port); end
        port_id = 8'hF1; step();
        checks++; if (in_port !== 8'h00) begin errors++; $display("FAIL reset_mask: got %h expected 00", in_port); end
        exp_regs = '0;
    endtask

    task automatic test_write();
        port_id = 8'h05; out_port = 8'hA7; write_strobe = 1'b1;
        step();
        exp_regs[5*8 +: 8] = 8'hA7;
        checks++; if (out_regs !== exp_regs) begin errors++; $display("FAIL write_value: got %h expected %h", out_regs, exp_regs); end
        checks++; if (out_wr_pulse !== 16'h0020) begin errors++; $display("FAIL write_pulse: got %h expected 0020", out_wr_pulse); end
        write_strobe = 1'b0; out_port = 8'h99;
        step();
        checks++; if (out_wr_pulse !== 16'h0000) begin errors++; $display("FAIL write_pulse_drop: got %h expected 0000", out_wr_pulse); end
        checks++; if (out_regs !== exp_regs) begin errors++; $display("FAIL write_hold: got %h expected %h", out_regs, exp_regs); end
        out_port = 8'hA7; write_strobe = 1'b1;
        step();
        write_strobe = 1'b0;
        checks++; if (out_wr_pulse !== 16'h0020) begin errors++; $display("FAIL write_same_value_pulse: got %h expected 0020", out_wr_pulse); end
        step();
    endtask

    task automatic test_k_write();
        port_id = 8'h13; out_port = 8'h3C; k_write_strobe = 1'b1;
        step();
        k_write_strobe = 1'b0;
        exp_regs[3*8 +: 8] = 8'h3C;
        checks++; if (out_regs !== exp_regs) begin errors++; $display("FAIL kwrite_alias: got %h expected %h", out_regs, exp_regs); end
        checks++; if (out_wr_pulse !== 16'h0008) begin errors++; $display("FAIL kwrite_pulse: got %h expected 0008", out_wr_pulse); end
        out_port = 8'h55; write_strobe = 1'b1;
        step();
        write_strobe = 1'b0;
        checks++; if (out_regs !== exp_regs) begin errors++; $display("FAIL write_unmapped: got %h expected %h", out_regs, exp_regs); end
        checks++; if (out_wr_pulse !== 16'h0000) begin errors++; $display("FAIL write_unmapped_pulse: got %h expected 0000", out_wr_pulse); end
        port_id = 8'h17; out_port = 8'h11; write_strobe = 1'b1; k_write_strobe = 1'b1;
        step();
        checks++; if (out_regs !== exp_regs) begin errors++; $display("FAIL priority_no_k: got %h expected %h", out_regs, exp_regs); end
        port_id = 8'h02; out_port = 8'h6B;
        step();
        idle();
        exp_regs[2*8 +: 8] = 8'h6B;
        checks++; if (out_regs !== exp_regs) begin errors++; $display("FAIL priority_both: got %h expected %h", out_regs, exp_regs); end
        checks++; if (out_wr_pulse !== 16'h0004) begin errors++; $display("FAIL priority_pulse: got %h expected 0004", out_wr_pulse); end
        step();
    endtask

    task automatic test_read();
        port_id = 8'h02;
        step();
        checks++; if (in_port !== 8'h5E) begin errors++; $display("FAIL read_port2: got %h expected 5E", in_port); end
        checks++; if (in_rd_pulse !== 4'h0) begin errors++; $display("FAIL read_no_strobe: got %h expected 0", in_rd_pulse); end
        read_strobe = 1'b1;
        step();
        read_strobe = 1'b0;
        checks++; if (in_rd_pulse !== 4'b0100) begin errors++; $display("FAIL read_pulse: got %b expected 0100", in_rd_pulse); end
        step();
        checks++; if (in_rd_pulse !== 4'h0) begin errors++; $display("FAIL read_pulse_drop: got %b expected 0000", in_rd_pulse); end
        port_id = 8'h80;
        step();
        checks++; if (in_port !== 8'h00) begin errors++; $display("FAIL read_unmapped: got %h expected 00", in_port); end
        port_id = 8'h05;
        step();
        checks++; if (in_port !== 8'h00) begin errors++; $display("FAIL read_outreg_above_nin: got %h expected 00", in_port); end
        port_id = 8'h03;
        step();
        checks++; if (in_port !== 8'h44) begin errors++; $display("FAIL read_port3: got %h expected 44", in_port); end
    endtask

    task automatic test_irq();
        irq_src = 4'h0;
        port_id = 8'hF1; out_port = 8'h01; write_strobe = 1'b1;
        step();
        write_strobe = 1'b0;
        step();
        checks++; if (in_port !== 8'h01) begin errors++; $display("FAIL mask_read: got %h expected 01", in_port); end
        port_id = 8'hF0;
        irq_src = 4'h1;
        step();
        checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL irq_t1: got %b expected 0", interrupt); end
        step();
        checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL irq_t2: got %b expected 1", interrupt); end
        checks++; if (in_port !== 8'h01) begin errors++; $display("FAIL irq_status: got %h expected 01", in_port); end
        interrupt_ack = 1'b1;
        step();
        interrupt_ack = 1'b0;
        checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL ack_drop: got %b expected 0", interrupt); end
        step();
        checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL ack_reassert: got %b expected 1", interrupt); end
        out_port = 8'h01; write_strobe = 1'b1;
        step();
        write_strobe = 1'b0;
        checks++; if (interrupt !== 1'b1) begin errors++; $display("FAIL w1c_t1: got %b expected 1", interrupt); end
        step();
        checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL w1c_t2: got %b expected 0", interrupt); end
        step();
        checks++; if (in_port !== 8'h00) begin errors++; $display("FAIL w1c_status: got %h expected 00", in_port); end
        irq_src = 4'h3; out_port = 8'h02; write_strobe = 1'b1;
        step();
        write_strobe = 1'b0;
        step();
        checks++; if (in_port !== 8'h02) begin errors++; $display("FAIL set_beats_clear: got %h expected 02", in_port); end
        step();
        checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL masked_source: got %b expected 0", interrupt); end
    endtask

    task automatic test_reset_mid();
        port_id = 8'h05; out_port = 8'hFF; write_strobe = 1'b1; read_strobe = 1'b1;
        irq_src = 4'hF; reset = 1'b1;
        step();
        idle();
        checks++; if (out_regs !== 128'h0) begin errors++; $display("FAIL mid_reset_regs: got %h expected 0", out_regs); end
        checks++; if (out_wr_pulse !== 16'h0) begin errors++; $display("FAIL mid_reset_wr_pulse: got %h expected 0", out_wr_pulse); end
        checks++; if (in_rd_pulse !== 4'h0) begin errors++; $display("FAIL mid_reset_rd_pulse: got %h expected 0", in_rd_pulse); end
        checks++; if (in_port !== 8'h00) begin errors++; $display("FAIL mid_reset_in_port: got %h expected 00", in_port); end
        reset = 1'b0; port_id = 8'hF0;
        step(); step();
        checks++; if (in_port !== 8'h00) begin errors++; $display("FAIL mid_reset_status: got %h expected 00", in_port); end
        port_id = 8'hF1;
        step();
        checks++; if (in_port !== 8'h00) begin errors++; $display("FAIL mid_reset_mask: got %h expected 00", in_port); end
        checks++; if (interrupt !== 1'b0) begin errors++; $display("FAIL mid_reset_interrupt: got %b expected 0", interrupt); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_k_write();
        test_read();
        test_irq();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
